// File: rtl/detector_jogada_pkg.sv
// Shared definitions for the memory-game input stage: FSM codes, default bus width
// and the one-hot test used on the synchronised button bus.
package detector_jogada_pkg;

  localparam int N_BOTOES_PADRAO = 4;
  localparam int VEC_MAX         = 32;

  localparam logic [1:0] OCIOSO      = 2'd0;
  localparam logic [1:0] ESTABILIZA  = 2'd1;
  localparam logic [1:0] PRESSIONADO = 2'd2;
  localparam logic [1:0] SOLTANDO    = 2'd3;

  // Callers zero-extend narrower buses to VEC_MAX bits.
  function automatic logic um_quente(input logic [VEC_MAX-1:0] v);
    return (v != '0) && ((v & (v - VEC_MAX'(1))) == '0);
  endfunction

endpackage

// File: rtl/detector_jogada_sincronizador_2ff.sv
// Two-flop synchroniser for an asynchronous bus; each bit is synchronised independently.
module sincronizador_2ff #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sinc_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      meta_q <= '0;
      sinc_q <= '0;
    end else begin
      meta_q <= d_i;
      sinc_q <= meta_q;
    end
  end

  assign q_o = sinc_q;

endmodule

// File: rtl/detector_jogada.sv
// Button input stage: synchronise, debounce press and release, accept single-button
// presses while enabled, and emit a latched one-hot move plus a one-cycle strobe.
module detector_jogada
  import detector_jogada_pkg::*;
#(
  parameter int N_BOTOES        = N_BOTOES_PADRAO,
  parameter int DEBOUNCE_CICLOS = 50000,
  parameter int W_CONT          = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                habilita,
  input  logic [N_BOTOES-1:0] botoes,
  output logic [N_BOTOES-1:0] jogada,
  output logic                jogada_feita,
  output logic                multiplos,
  output logic [3:0]          db_estado
);

  localparam logic [W_CONT-1:0] LIMITE = W_CONT'(DEBOUNCE_CICLOS - 1);

  logic [N_BOTOES-1:0] sb;

  logic [1:0]          estado_q, estado_d;
  logic [W_CONT-1:0]   cont_q,   cont_d;
  logic [N_BOTOES-1:0] cand_q,   cand_d;
  logic [N_BOTOES-1:0] jogada_q, jogada_d;
  logic                feita_q,  feita_d;
  logic                mult_q,   mult_d;
  logic                sb_um;

  sincronizador_2ff #(.W(N_BOTOES)) u_sinc (
    .clk_i  (clock),
    .rst_n_i(reset),
    .d_i    (botoes),
    .q_o    (sb)
  );

  assign sb_um = um_quente(VEC_MAX'(sb));

  always_comb begin
    estado_d = estado_q;
    cont_d   = cont_q;
    cand_d   = cand_q;
    jogada_d = jogada_q;
    feita_d  = 1'b0;
    mult_d   = (estado_q == OCIOSO) && (sb != '0) && !sb_um;

    case (estado_q)
      OCIOSO: begin
        cont_d = '0;
        if (habilita && sb_um) begin
          estado_d = ESTABILIZA;
          cand_d   = sb;
        end
      end
      ESTABILIZA: begin
        // Any bus change or loss of the turn restarts detection from idle.
        if ((sb != cand_q) || !habilita) begin
          estado_d = OCIOSO;
          cont_d   = '0;
        end else if (cont_q == LIMITE) begin
          estado_d = PRESSIONADO;
          jogada_d = cand_q;
          feita_d  = 1'b1;
          cont_d   = '0;
        end else begin
          cont_d = cont_q + W_CONT'(1);
        end
      end
      PRESSIONADO: begin
        cont_d = '0;
        if (sb == '0) estado_d = SOLTANDO;
      end
      SOLTANDO: begin
        if (sb != '0) begin
          estado_d = PRESSIONADO;
          cont_d   = '0;
        end else if (cont_q == LIMITE) begin
          estado_d = OCIOSO;
          cont_d   = '0;
        end else begin
          cont_d = cont_q + W_CONT'(1);
        end
      end
      default: begin
        estado_d = OCIOSO;
        cont_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q <= OCIOSO;
      cont_q   <= '0;
      cand_q   <= '0;
      jogada_q <= '0;
      feita_q  <= 1'b0;
      mult_q   <= 1'b0;
    end else begin
      estado_q <= estado_d;
      cont_q   <= cont_d;
      cand_q   <= cand_d;
      jogada_q <= jogada_d;
      feita_q  <= feita_d;
      mult_q   <= mult_d;
    end
  end

  assign jogada       = jogada_q;
  assign jogada_feita = feita_q;
  assign multiplos    = mult_q;
  assign db_estado    = {2'b00, estado_q};

endmodule

// File: tb/tb_detector_jogada.sv
// Directed bench for detector_jogada with a 4-cycle debounce window.
module tb_detector_jogada;

  localparam int NB = 4;
  localparam int DB = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          habilita;
  logic [NB-1:0] botoes;
  logic [NB-1:0] jogada;
  logic          jogada_feita;
  logic          multiplos;
  logic [3:0]    db_estado;

  int n_cmp = 0;
  int n_err = 0;

  detector_jogada #(.N_BOTOES(NB), .DEBOUNCE_CICLOS(DB), .W_CONT(16)) dut (
    .clock       (clock),
    .reset       (reset),
    .habilita    (habilita),
    .botoes      (botoes),
    .jogada      (jogada),
    .jogada_feita(jogada_feita),
    .multiplos   (multiplos),
    .db_estado   (db_estado)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Runs n edges; reports strobe count and the 1-based edge index of the first strobe.
  task automatic run(input int n, output int cnt, output int first);
    cnt   = 0;
    first = 0;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (jogada_feita) begin
        cnt++;
        if (first == 0) first = i;
      end
    end
  endtask

  initial begin
    int c, f, tot;

    reset = 1'b0; habilita = 1'b1; botoes = '0;
    tick(); tick();
    chk("rst_jogada", 32'(jogada), 0);
    chk("rst_feita",  32'(jogada_feita), 0);
    chk("rst_mult",   32'(multiplos), 0);
    chk("rst_estado", 32'(db_estado), 0);
    reset = 1'b1;
    tick();

    // Clean press
    botoes = 4'b0010;
    run(3, c, f);
    chk("limpo_pre_n", c, 0);
    chk("limpo_estab", 32'(db_estado), 1);
    run(4, c, f);
    chk("limpo_lat",   f, 4);
    chk("limpo_n",     c, 1);
    chk("limpo_jog",   32'(jogada), 4'b0010);
    chk("limpo_press", 32'(db_estado), 2);
    run(13, c, f);
    chk("limpo_hold_n", c, 0);
    botoes = 4'b0000;
    run(3, c, f);
    chk("limpo_solt", 32'(db_estado), 3);
    run(4, c, f);
    chk("limpo_ocioso", 32'(db_estado), 0);
    chk("limpo_jog2",   32'(jogada), 4'b0010);

    // Bounce
    tot = 0;
    for (int k = 0; k < 3; k++) begin
      botoes = 4'b0100; run(2, c, f); tot += c;
      botoes = 4'b0000; run(2, c, f); tot += c;
    end
    chk("bounce_n", tot, 0);
    botoes = 4'b0100;
    run(10, c, f);
    chk("bounce_lat", f, 7);
    chk("bounce_nn",  c, 1);
    chk("bounce_jog", 32'(jogada), 4'b0100);
    botoes = 4'b0000;
    run(8, c, f);
    chk("bounce_rel", 32'(db_estado), 0);

    // Disabled
    habilita = 1'b0; botoes = 4'b0001;
    run(20, c, f);
    chk("desab_n",   c, 0);
    chk("desab_jog", 32'(jogada), 4'b0100);
    chk("desab_est", 32'(db_estado), 0);
    habilita = 1'b1;
    run(5, c, f);
    chk("hab_lat", f, 5);
    chk("hab_n",   c, 1);
    chk("hab_jog", 32'(jogada), 4'b0001);
    botoes = 4'b0000;
    run(8, c, f);

    // Multiple buttons
    botoes = 4'b1001;
    run(2, c, f);
    chk("mult_early", 32'(multiplos), 0);
    run(1, c, f);
    chk("mult_on", 32'(multiplos), 1);
    run(10, c, f);
    chk("mult_hold", 32'(multiplos), 1);
    chk("mult_n",    c, 0);
    botoes = 4'b1000;
    run(7, c, f);
    chk("mult_off", 32'(multiplos), 0);
    chk("mult_lat", f, 7);
    chk("mult_jog", 32'(jogada), 4'b1000);
    botoes = 4'b0000;
    run(8, c, f);

    // Repeat and release glitch
    botoes = 4'b0001;
    run(7, c, f);
    chk("rep1_lat", f, 7);
    botoes = 4'b0000;
    run(3, c, f);
    chk("glitch_solt", 32'(db_estado), 3);
    botoes = 4'b0001; run(1, c, f); tot = c;
    botoes = 4'b0000; run(2, c, f); tot += c;
    chk("glitch_press", 32'(db_estado), 2);
    run(8, c, f); tot += c;
    chk("glitch_n",   tot, 0);
    chk("glitch_ocs", 32'(db_estado), 0);
    botoes = 4'b0001;
    run(7, c, f);
    chk("rep2_lat", f, 7);
    chk("rep2_n",   c, 1);
    botoes = 4'b0000;
    run(8, c, f);

    // Reset mid-press
    botoes = 4'b0010;
    run(3, c, f);
    chk("rstm_estab", 32'(db_estado), 1);
    reset = 1'b0;
    #1;
    chk("rstm_jog",  32'(jogada), 0);
    chk("rstm_feit", 32'(jogada_feita), 0);
    chk("rstm_mult", 32'(multiplos), 0);
    chk("rstm_est",  32'(db_estado), 0);
    run(2, c, f);
    chk("rstm_n", c, 0);
    reset = 1'b1;
    run(9, c, f);
    chk("rstm_lat", f, 7);
    chk("rstm_nn",  c, 1);
    chk("rstm_j2",  32'(jogada), 4'b0010);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
